pir_alarm_scheduler: RTL and testbench
======================================

# pir_alarm_scheduler

Sequencing controller for the three-sensor PIR alarm path. Detects threshold crossings on each 7-bit PIR channel and arbitrates the channels round-robin onto one shared event-log write port, one record per cycle. Runs the arm/alarm/timeout state machine that drives the buzzer and per-sensor LEDs. Sits between the raw sensor inputs and the event RAM / display logic.

## Interface
- `THRESHOLD`, default 50: trigger level. A channel is "over" when its value ≥ THRESHOLD, unsigned 7-bit compare.
- `BUZZ_CYCLES`, default 100: alarm duration in clock cycles.
- `LOG_DEPTH`, default 8: event-log entries. Must be a power of 2.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `turn  in  1`: arm request. 1 arms the system, 0 disarms it.
- `stop_alarm  in  1`: operator acknowledge.
- `pir_sensor_1`, `pir_sensor_2`, `pir_sensor_3  in  7 each`: sensor readings.
- `LED  out  3`: bit i lit once channel i+1 has been logged during the current alarm.
- `buzzer  out  1`: high while in ALARM.
- `log_wr_en  out  1`: one-cycle write strobe.
- `log_wr_addr  out  log2(LOG_DEPTH)`: write address.
- `log_wr_data  out  9`: record, `{sensor_id[1:0], value[6:0]}`, with sensor_id 1..3.
- `event_count  out  8`: total records written. Saturates at 255.
- `fsm_state  out  2`: current state code.

## Operation
- States and codes: DISARMED = 0, ARMED = 1, ALARM = 2, HOLDOFF = 3.
- Reset values:
  - All outputs 0.
  - State DISARMED.
  - Pending bits, over_q bits and log pointer 0.
  - Round-robin pointer points at channel 3, so channel 1 has first priority.
- Edge detect: `over_q[i]` registers "over" every cycle in every state. `pending[i]` sets when over=1 and over_q=0, but only in ARMED or ALARM.
- Pending set/clear conflict: if a grant clears `pending[i]` on the same edge a new rising edge sets it, set wins.
- Arbiter: one grant per cycle among the pending bits, in ARMED or ALARM only.
  - Round-robin search starts at the channel after the last granted one.
  - The granted pending bit clears.
  - The record is written with `log_wr_data` = {id, the current sensor value}.
  - `log_wr_addr` = log pointer, which then increments mod LOG_DEPTH. It wraps silently and overwrites the oldest entry.
  - `event_count` increments and holds at 255.
- DISARMED:
  - Pending bits cleared and LEDs cleared.
  - When turn=1, go to ARMED.
- ARMED:
  - If turn=0, go to DISARMED (takes priority).
  - Otherwise, any grant moves to ALARM, clears the buzz counter and sets the LED bit of the granted channel.
- ALARM:
  - buzzer=1.
  - Each grant sets its LED bit.
  - The buzz counter increments every cycle.
  - Exit priority, highest first:
    1. turn=0 → DISARMED.
    2. stop_alarm=1 → HOLDOFF.
    3. Counter reaches BUZZ_CYCLES−1 → HOLDOFF.
- HOLDOFF: a single cycle.
  - buzzer=0, LEDs cleared, pending bits cleared.
  - Next state is ARMED if turn=1, else DISARMED.
  - No grants in this state.
- Reset asserted mid-alarm forces the reset values immediately, asynchronously. A log write in flight is dropped.

## Timing
- The sensor value crosses threshold before clock edge k, so "over" is true at edge k. At edge k, `pending` is set.
- At edge k+1: the grant is registered; `log_wr_en`, `log_wr_addr` and `log_wr_data` are valid for the cycle after k+1; the state moves ARMED→ALARM; buzzer goes high.
- Write latency is 2 edges from the first "over" edge to the registered strobe.
- The data field captures the sensor value present at the grant edge, not the crossing edge.
- N simultaneous crossings produce N consecutive write cycles, in round-robin order.
- Buzzer high time with no stop is exactly BUZZ_CYCLES cycles, then one HOLDOFF cycle.
- `stop_alarm` is sampled at the edge. It takes effect one cycle later, with buzzer low in the following cycle.
- `fsm_state` and every output are registered; nothing is combinational from inputs to outputs.

## Configuration
- `PIR_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority, channel 1 > 2 > 3. The round-robin pointer is removed.
  - Undefined (default): round-robin as specified above.
- All other behaviour is identical in both builds.

## Test plan
- **Reset/arm:** assert rst; apply turn=1 → all outputs 0, then fsm_state 1 after one edge.
- **Single trigger:** armed, set pir_sensor_2 = 0→60 → `log_wr_en` pulses once, 2 edges later, with data {2,60} at addr 0. LED = 3'b010, buzzer=1. After 100 cycles buzzer drops, one HOLDOFF cycle, back to ARMED. event_count = 1.
- **Simultaneous:** all three sensors 0→70 on the same edge → three consecutive writes at addrs 0, 1, 2 with ids 1, 2, 3. Repeat the crossing → ids start at 1 again, since the pointer was last at 3. With `PIR_SCHED_FIXED_PRIO_EN` defined the order is always 1, 2, 3.
- **Level held:** sensor_1 held at 90 for 500 cycles → exactly one record logged. Drop to 10, raise to 90 → a second record.
- **Stop/disarm:** ALARM with stop_alarm=1 at cycle 20 → HOLDOFF, LED = 0, ARMED. Separately, turn=0 during ALARM → DISARMED and buzzer 0 next cycle.
- **Wrap/saturate:** 9 distinct events → the 9th writes addr 0. 300 events → event_count = 255. Async rst mid-alarm → buzzer 0 without a clock edge.

Source files
------------

// File: rtl/pir_alarm_scheduler_if.sv
// Event-log write port between pir_alarm_scheduler (master) and the event RAM (slave).
interface pir_alarm_scheduler_if #(
   parameter int unsigned LOG_DEPTH = 8
);
   localparam int ADDR_W = $clog2(LOG_DEPTH);

   logic              log_wr_en;
   logic [ADDR_W-1:0] log_wr_addr;
   logic [8:0]        log_wr_data;

   modport master (output log_wr_en, output log_wr_addr, output log_wr_data);
   modport slave  (input  log_wr_en, input  log_wr_addr, input  log_wr_data);
endinterface

// File: rtl/pir_alarm_scheduler.sv
// Three-channel PIR edge detect, log-port arbiter and arm/alarm/holdoff FSM.
// Define PIR_SCHED_FIXED_PRIO_EN for fixed priority (1 > 2 > 3) instead of round-robin.
module pir_alarm_scheduler #(
   parameter int unsigned THRESHOLD   = 50,
   parameter int unsigned BUZZ_CYCLES = 100,
   parameter int unsigned LOG_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          turn,
   input  logic                          stop_alarm,
   input  logic [6:0]                    pir_sensor_1,
   input  logic [6:0]                    pir_sensor_2,
   input  logic [6:0]                    pir_sensor_3,
   output logic [2:0]                    LED,
   output logic                          buzzer,
   pir_alarm_scheduler_if.master         log,
   output logic [7:0]                    event_count,
   output logic [1:0]                    fsm_state
);
   localparam int ADDR_W = $clog2(LOG_DEPTH);
   localparam int CNT_W  = $clog2(BUZZ_CYCLES + 1);

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      ALARM    = 2'd2,
      HOLDOFF  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        over, over_q, rise;
   logic [2:0]        pending_q, pending_d;
   logic [2:0]        led_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] ptr_q;
   logic              arb_en;
   logic              gnt_vld;
   logic [1:0]        gnt_idx;
   logic [6:0]        gnt_val;

   assign over = {32'(pir_sensor_3) >= THRESHOLD,
                  32'(pir_sensor_2) >= THRESHOLD,
                  32'(pir_sensor_1) >= THRESHOLD};
   assign rise      = over & ~over_q;
   assign arb_en    = (state_q == ARMED) || (state_q == ALARM);
   assign fsm_state = state_q;

`ifdef PIR_SCHED_FIXED_PRIO_EN
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = 2'd0;
      for (int i = 0; i < 3; i++) begin
         if (arb_en && !gnt_vld && pending_q[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = 2'(i);
         end
      end
   end
`else
   logic [1:0] rr_q;
   logic [1:0] cand;

   function automatic logic [1:0] next_ch(input logic [1:0] c);
      return (c == 2'd2) ? 2'd0 : c + 2'd1;
   endfunction

   // Search begins at the channel after the last one granted.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = 2'd0;
      cand    = rr_q;
      for (int i = 0; i < 3; i++) begin
         cand = next_ch(cand);
         if (arb_en && !gnt_vld && pending_q[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rr_q <= 2'd2;
      else if (gnt_vld) rr_q <= gnt_idx;
   end
`endif

   always_comb begin
      case (gnt_idx)
         2'd0:    gnt_val = pir_sensor_1;
         2'd1:    gnt_val = pir_sensor_2;
         default: gnt_val = pir_sensor_3;
      endcase
   end

   // A new rising edge beats a grant clearing the same bit.
   always_comb begin
      pending_d = pending_q;
      if (gnt_vld) pending_d[gnt_idx] = 1'b0;
      if (arb_en)  pending_d = pending_d | rise;
      if (state_q == DISARMED || state_q == HOLDOFF) pending_d = '0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      led_d   = LED;
      case (state_q)
         DISARMED: if (turn) state_d = ARMED;
         ARMED: begin
            if (!turn) begin
               state_d = DISARMED;
            end else if (gnt_vld) begin
               state_d        = ALARM;
               cnt_d          = '0;
               led_d[gnt_idx] = 1'b1;
            end
         end
         ALARM: begin
            if (gnt_vld) led_d[gnt_idx] = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (!turn)                                state_d = DISARMED;
            else if (stop_alarm)                      state_d = HOLDOFF;
            else if (cnt_q == CNT_W'(BUZZ_CYCLES - 1)) state_d = HOLDOFF;
         end
         HOLDOFF: state_d = turn ? ARMED : DISARMED;
         default: state_d = DISARMED;
      endcase
      if (state_d == DISARMED || state_d == HOLDOFF) led_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= DISARMED;
         over_q          <= '0;
         pending_q       <= '0;
         cnt_q           <= '0;
         ptr_q           <= '0;
         LED             <= '0;
         buzzer          <= 1'b0;
         event_count     <= '0;
         log.log_wr_en   <= 1'b0;
         log.log_wr_addr <= '0;
         log.log_wr_data <= '0;
      end else begin
         state_q       <= state_d;
         over_q        <= over;
         pending_q     <= pending_d;
         cnt_q         <= cnt_d;
         LED           <= led_d;
         buzzer        <= (state_d == ALARM);
         log.log_wr_en <= gnt_vld;
         if (gnt_vld) begin
            log.log_wr_addr <= ptr_q;
            log.log_wr_data <= {gnt_idx + 2'd1, gnt_val};
            ptr_q           <= ptr_q + ADDR_W'(1);
            if (event_count != 8'd255) event_count <= event_count + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_pir_alarm_scheduler.sv
// Directed bench for pir_alarm_scheduler with hand-computed expectations.
module tb_pir_alarm_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       turn = 1'b0;
   logic       stop_alarm = 1'b0;
   logic [6:0] s1 = 7'd0, s2 = 7'd0, s3 = 7'd0;
   logic [2:0] LED;
   logic       buzzer;
   logic [7:0] event_count;
   logic [1:0] fsm_state;
   int         checks = 0;
   int         failures = 0;
   int         n, wr;
   logic [8:0] d;

   pir_alarm_scheduler_if #(.LOG_DEPTH(8)) lif();

   pir_alarm_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .turn        (turn),
      .stop_alarm  (stop_alarm),
      .pir_sensor_1(s1),
      .pir_sensor_2(s2),
      .pir_sensor_3(s3),
      .LED         (LED),
      .buzzer      (buzzer),
      .log         (lif),
      .event_count (event_count),
      .fsm_state   (fsm_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; turn = 1'b0; stop_alarm = 1'b0;
      s1 = 7'd0; s2 = 7'd0; s3 = 7'd0;
      step;
      rst = 1'b0; turn = 1'b1;
      step;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and arm
      step; step;
      chk("rst_led", LED, 0);
      chk("rst_buzzer", buzzer, 0);
      chk("rst_wr_en", lif.log_wr_en, 0);
      chk("rst_wr_addr", lif.log_wr_addr, 0);
      chk("rst_wr_data", lif.log_wr_data, 0);
      chk("rst_count", event_count, 0);
      chk("rst_state", fsm_state, 0);
      rst = 1'b0; turn = 1'b1;
      step;
      chk("arm_state", fsm_state, 1);

      // Single trigger on channel 2
      s2 = 7'd60;
      step;
      chk("single_lat_en", lif.log_wr_en, 0);
      step;
      chk("single_en", lif.log_wr_en, 1);
      chk("single_addr", lif.log_wr_addr, 0);
      chk("single_data", lif.log_wr_data, (2 << 7) | 60);
      chk("single_led", LED, 3'b010);
      chk("single_buzzer", buzzer, 1);
      chk("single_state", fsm_state, 2);
      chk("single_count", event_count, 1);
      n = 1; wr = 0;
      for (int i = 0; i < 300; i++) begin
         step;
         if (lif.log_wr_en) wr++;
         if (!buzzer) break;
         n++;
      end
      chk("single_buzz_len", n, 100);
      chk("single_extra_wr", wr, 0);
      chk("single_holdoff", fsm_state, 3);
      chk("single_holdoff_led", LED, 0);
      step;
      chk("single_rearm", fsm_state, 1);
      s2 = 7'd0;
      step;

      // Simultaneous crossings, twice
      do_reset;
      s1 = 7'd70; s2 = 7'd70; s3 = 7'd70;
      step;
      for (int i = 0; i < 3; i++) begin
         step;
         chk("sim1_en", lif.log_wr_en, 1);
         chk("sim1_addr", lif.log_wr_addr, i);
         chk("sim1_data", lif.log_wr_data, ((i + 1) << 7) | 70);
      end
      chk("sim1_led", LED, 3'b111);
      s1 = 7'd0; s2 = 7'd0; s3 = 7'd0;
      step; step;
      s1 = 7'd70; s2 = 7'd70; s3 = 7'd70;
      step;
      for (int i = 0; i < 3; i++) begin
         step;
         chk("sim2_en", lif.log_wr_en, 1);
         chk("sim2_addr", lif.log_wr_addr, 3 + i);
         chk("sim2_data", lif.log_wr_data, ((i + 1) << 7) | 70);
      end
      chk("sim2_count", event_count, 6);

      // Operator stop during alarm
      s1 = 7'd0; s2 = 7'd0; s3 = 7'd0;
      repeat (10) step;
      chk("stop_pre_state", fsm_state, 2);
      stop_alarm = 1'b1;
      step;
      chk("stop_state", fsm_state, 3);
      chk("stop_buzzer", buzzer, 0);
      chk("stop_led", LED, 0);
      stop_alarm = 1'b0;
      step;
      chk("stop_rearm", fsm_state, 1);

      // Level held: one record, then a second after re-crossing
      do_reset;
      s1 = 7'd90; wr = 0;
      for (int i = 0; i < 500; i++) begin
         step;
         if (lif.log_wr_en) wr++;
      end
      chk("level_records", wr, 1);
      s1 = 7'd10;
      step;
      s1 = 7'd90; wr = 0; d = '0;
      for (int i = 0; i < 4; i++) begin
         step;
         if (lif.log_wr_en) begin
            wr++;
            d = lif.log_wr_data;
         end
      end
      chk("level_second", wr, 1);
      chk("level_second_data", d, (1 << 7) | 90);
      chk("level_alarm", fsm_state, 2);

      // Disarm during alarm
      turn = 1'b0;
      step;
      chk("disarm_state", fsm_state, 0);
      chk("disarm_buzzer", buzzer, 0);
      chk("disarm_led", LED, 0);

      // Address wrap after eight entries
      do_reset;
      for (int i = 0; i < 9; i++) begin
         s1 = 7'd90;
         step; step;
         chk("wrap_en", lif.log_wr_en, 1);
         chk("wrap_addr", lif.log_wr_addr, i % 8);
         s1 = 7'd0;
         step;
      end

      // Event counter saturation
      for (int i = 0; i < 300; i++) begin
         s1 = 7'd90;
         step; step;
         s1 = 7'd0;
         step;
      end
      chk("sat_count", event_count, 255);

      // Asynchronous reset in the middle of an alarm
      turn = 1'b0;
      step;
      turn = 1'b1;
      step;
      s2 = 7'd90;
      step; step;
      chk("arst_pre_state", fsm_state, 2);
      chk("arst_pre_buzzer", buzzer, 1);
      chk("arst_pre_en", lif.log_wr_en, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_buzzer", buzzer, 0);
      chk("arst_state", fsm_state, 0);
      chk("arst_count", event_count, 0);
      chk("arst_en", lif.log_wr_en, 0);
      chk("arst_led", LED, 0);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
